// File: rtl/rx_proto_pkg.sv
// Shared definitions for the receive-side command protocol: command bytes,
// FSM state encoding, error codes and operand byte-count helper.
package rx_proto_pkg;

  localparam logic [7:0] CMD_CONFIG_DEF  = 8'hCD;
  localparam logic [7:0] CMD_DISPLAY_DEF = 8'hD1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECV_A   = 3'd1,
    ST_RECV_B   = 3'd2,
    ST_RECV_OP  = 3'd3,
    ST_RECV_CHK = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;

  function automatic int calc_nb(input int data_w);
    return (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte watchdog. The abort it triggers is registered one clock after
// expire, so the counter loads CYCLES-2 to land the error CYCLES clocks after the last byte.
module rx_timeout_counter #(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int               CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'((CYCLES > 2) ? CYCLES - 2 : 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (clr)                cnt <= LOAD;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  // A byte in the expiry cycle (clr) always wins over the timeout.
  assign expire = en && !clr && (cnt == '0);

endmodule

// File: rtl/rx_frame_controller.sv
// Receive-side frame FSM: assembles {op, B, A} from a byte stream with
// optional XOR checksum and inter-byte timeout, reporting aborts as error pulses.
module rx_frame_controller
  import rx_proto_pkg::*;
#(
  parameter int         DATA_W         = 8,
  parameter int         OP_W           = 6,
  parameter logic [7:0] CMD_CONFIG     = CMD_CONFIG_DEF,
  parameter logic [7:0] CMD_DISPLAY    = CMD_DISPLAY_DEF,
  parameter int         CHK_EN         = 0,
  parameter int         TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     data_ready_pulse,
  input  logic [7:0]               data_in,
  output logic [OP_W+2*DATA_W-1:0] alu_data_out,
  output logic                     reg_load_pulse,
  output logic                     display_cmd_pulse,
  output logic                     frame_err_pulse,
  output logic [1:0]               frame_err_code,
  output logic                     busy
);
  localparam int              NB      = calc_nb(DATA_W);
  localparam int              BC_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB - 1);

  state_t            state, state_nxt;
  logic [BC_W-1:0]   byte_cnt;
  logic [7:0]        chk;
  logic [DATA_W-1:0] a_sh, b_sh;
  logic [OP_W-1:0]   op_sh, op_cur;
  logic              disp_q, err_q, tmo_expire;
  logic              idle_like, last_byte, chk_ok;

  // Little-endian byte insert; bits of byte k beyond DATA_W fall away.
  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] cur,
                                                 input logic [7:0]        b,
                                                 input logic [BC_W-1:0]   k);
    logic [DATA_W-1:0] r;
    r = cur;
    for (int i = 0; i < DATA_W; i++)
      if (i / 8 == int'(k)) r[i] = b[3'(i % 8)];
    return r;
  endfunction

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign last_byte = (byte_cnt == BC_LAST);
  assign op_cur    = (state == ST_RECV_OP) ? data_in[OP_W-1:0] : op_sh;
  assign chk_ok    = (data_in == chk);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      rx_timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (data_ready_pulse || !busy),
        .en     (busy),
        .expire (tmo_expire)
      );
    end else begin : g_no_tmo
      assign tmo_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE:
        state_nxt = (data_ready_pulse && data_in == CMD_CONFIG) ? ST_RECV_A : ST_IDLE;
      ST_RECV_A:
        if (tmo_expire)                         state_nxt = ST_IDLE;
        else if (data_ready_pulse && last_byte) state_nxt = ST_RECV_B;
      ST_RECV_B:
        if (tmo_expire)                         state_nxt = ST_IDLE;
        else if (data_ready_pulse && last_byte) state_nxt = ST_RECV_OP;
      ST_RECV_OP:
        if (tmo_expire)            state_nxt = ST_IDLE;
        else if (data_ready_pulse) state_nxt = (CHK_EN != 0) ? ST_RECV_CHK : ST_DONE;
      ST_RECV_CHK:
        if (tmo_expire)            state_nxt = ST_IDLE;
        else if (data_ready_pulse) state_nxt = chk_ok ? ST_DONE : ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    reg_load_pulse = 1'b0;
    case (state)
      ST_RECV_A, ST_RECV_B, ST_RECV_OP, ST_RECV_CHK: busy = 1'b1;
      ST_DONE:                                       reg_load_pulse = 1'b1;
      default: ;
    endcase
  end

  assign display_cmd_pulse = disp_q;
  assign frame_err_pulse   = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt       <= '0;
      chk            <= '0;
      a_sh           <= '0;
      b_sh           <= '0;
      op_sh          <= '0;
      alu_data_out   <= '0;
      disp_q         <= 1'b0;
      err_q          <= 1'b0;
      frame_err_code <= ERR_NONE;
    end else begin
      disp_q <= idle_like && data_ready_pulse && (data_in == CMD_DISPLAY);
      err_q  <= 1'b0;
      if (data_ready_pulse) begin
        case (state)
          ST_IDLE, ST_DONE:
            if (data_in == CMD_CONFIG) begin
              byte_cnt <= '0;
              chk      <= '0;
            end
          ST_RECV_A: begin
            a_sh     <= put_byte(a_sh, data_in, byte_cnt);
            chk      <= chk ^ data_in;
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
          end
          ST_RECV_B: begin
            b_sh     <= put_byte(b_sh, data_in, byte_cnt);
            chk      <= chk ^ data_in;
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
          end
          ST_RECV_OP: begin
            op_sh <= data_in[OP_W-1:0];
            chk   <= chk ^ data_in;
          end
          ST_RECV_CHK:
            if (!chk_ok) begin
              err_q          <= 1'b1;
              frame_err_code <= ERR_CHK;
            end
          default: ;
        endcase
      end
      if (tmo_expire) begin
        err_q          <= 1'b1;
        frame_err_code <= ERR_TIMEOUT;
      end
      // Only a completed frame reaches DONE, so aborts never touch the output.
      if (state_nxt == ST_DONE) alu_data_out <= {op_cur, b_sh, a_sh};
    end
  end

endmodule

// File: tb/tb_rx_frame_controller.sv
// Five differently configured controllers share one byte stream; each is
// compared every cycle against a frame-level byte-queue model.
module tb_rx_frame_controller;
  localparam int NI = 5;

  function automatic int dw_of(input int g);
    case (g)
      1:       return 16;
      2:       return 12;
      default: return 8;
    endcase
  endfunction
  function automatic int chk_of(input int g); return (g == 3) ? 1 : 0;   endfunction
  function automatic int to_of(input int g);  return (g == 4) ? 100 : 0; endfunction

  logic        clk = 1'b0, reset_n = 1'b0, drp = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [63:0] alu_o [NI];
  logic [1:0]  ec_o  [NI];
  logic [NI-1:0] ld_o, dp_o, ep_o, by_o;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW = dw_of(g);
    logic [6+2*DW-1:0] alu;
    rx_frame_controller #(.DATA_W(DW), .OP_W(6), .CHK_EN(chk_of(g)),
                          .TIMEOUT_CYCLES(to_of(g))) u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .data_ready_pulse (drp),
      .data_in          (din),
      .alu_data_out     (alu),
      .reg_load_pulse   (ld_o[g]),
      .display_cmd_pulse(dp_o[g]),
      .frame_err_pulse  (ep_o[g]),
      .frame_err_code   (ec_o[g]),
      .busy             (by_o[g])
    );
    assign alu_o[g] = 64'(alu);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is just a list of bytes; outputs follow from it.
  int          m_in  [NI];
  int          m_len [NI];
  int          m_sil [NI];
  logic [7:0]  m_fb  [NI][16];
  logic [63:0] e_alu [NI];
  logic [1:0]  e_ec  [NI];
  logic [NI-1:0] e_ld, e_dp, e_ep;

  function automatic logic [63:0] assemble(input int g);
    int dw, nb;
    logic [63:0] a, b, op, msk;
    dw = dw_of(g); nb = (dw + 7) / 8; a = 0; b = 0;
    for (int k = 0; k < nb; k++) begin
      a |= 64'(m_fb[g][k])      << (8 * k);
      b |= 64'(m_fb[g][nb + k]) << (8 * k);
    end
    msk = (64'd1 << dw) - 1;
    op  = 64'(m_fb[g][2 * nb] & 8'h3F);
    return (op << (2 * dw)) | ((b & msk) << dw) | (a & msk);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < NI; g++) begin
        m_in[g] = 0; m_len[g] = 0; m_sil[g] = 0; e_alu[g] = 0; e_ec[g] = 0;
      end
      e_ld = 0; e_dp = 0; e_ep = 0;
    end else begin
      for (int g = 0; g < NI; g++) begin
        int flen;
        logic [7:0] x;
        flen = 2 * ((dw_of(g) + 7) / 8) + 1 + chk_of(g);
        e_ld[g] = 0; e_dp[g] = 0; e_ep[g] = 0;
        if (m_in[g] != 0) begin
          if (drp) begin
            m_fb[g][m_len[g]] = din; m_len[g]++; m_sil[g] = 0;
            if (m_len[g] == flen) begin
              m_in[g] = 0; x = 0;
              for (int k = 0; k < flen - 1; k++) x ^= m_fb[g][k];
              if (chk_of(g) != 0 && x != m_fb[g][flen-1]) begin
                e_ep[g] = 1; e_ec[g] = 2;
              end else begin
                e_alu[g] = assemble(g); e_ld[g] = 1;
              end
            end
          end else begin
            m_sil[g]++;
            // Abort becomes visible TO clocks after the last byte strobe.
            if (to_of(g) > 0 && m_sil[g] >= to_of(g) - 1) begin
              m_in[g] = 0; e_ep[g] = 1; e_ec[g] = 1;
            end
          end
        end else if (drp) begin
          if (din == 8'hCD) begin m_in[g] = 1; m_len[g] = 0; m_sil[g] = 0; end
          else if (din == 8'hD1) e_dp[g] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int g = 0; g < NI; g++) begin
        check($sformatf("d%0d_alu", g),  alu_o[g],        e_alu[g]);
        check($sformatf("d%0d_load", g), 64'(ld_o[g]),    64'(e_ld[g]));
        check($sformatf("d%0d_disp", g), 64'(dp_o[g]),    64'(e_dp[g]));
        check($sformatf("d%0d_err", g),  64'(ep_o[g]),    64'(e_ep[g]));
        check($sformatf("d%0d_code", g), 64'(ec_o[g]),    64'(e_ec[g]));
        check($sformatf("d%0d_busy", g), 64'(by_o[g]),    64'(m_in[g] != 0));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    drp = 1'b1; din = b;
    @(negedge clk);
    drp = 1'b0; din = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    idle(2);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_alu%0d", g),  alu_o[g],     64'h0);
      check($sformatf("rst_busy%0d", g), 64'(by_o[g]), 64'h0);
      check($sformatf("rst_code%0d", g), 64'(ec_o[g]), 64'h0);
    end
    reset_n = 1'b1;
    idle(1);

    // Basic 8-bit frame, then checksum good / bad on the CHK instance.
    send_byte(8'hCD); send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    check("t1_load",  64'(ld_o[0]), 64'h1);
    check("t1_alu",   alu_o[0],     64'h200305);
    send_byte(8'h26);
    check("t1_load_once", 64'(ld_o[0]), 64'h0);
    check("t3_load",  64'(ld_o[3]), 64'h1);
    check("t3_alu",   alu_o[3],     64'h200305);
    send_byte(8'hCD); send_byte(8'h05); send_byte(8'h03); send_byte(8'h20); send_byte(8'h27);
    check("t3_err",   64'(ep_o[3]), 64'h1);
    check("t3_code",  64'(ec_o[3]), 64'h2);
    check("t3_noload",64'(ld_o[3]), 64'h0);
    check("t3_hold",  alu_o[3],     64'h200305);

    // Multi-byte operands.
    do_reset();
    send_byte(8'hCD); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h22);
    check("t2_load16", 64'(ld_o[1]), 64'h1);
    check("t2_alu16",  alu_o[1],     64'h22_5678_1234);
    check("t2_alu12",  alu_o[2],     64'h2267_8234);

    // Timeout exactly 100 clocks after the last strobe.
    do_reset();
    send_byte(8'hCD); send_byte(8'h05);
    for (int k = 1; k <= 100; k++) begin
      check($sformatf("t4_err_k%0d", k), 64'(ep_o[4]), 64'(k == 100));
      if (k >= 99) check($sformatf("t4_busy_k%0d", k), 64'(by_o[4]), 64'(k == 99));
      if (k < 100) idle(1);
    end
    check("t4_code", 64'(ec_o[4]), 64'h1);
    idle(1);
    send_byte(8'hCD); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check("t4_load", 64'(ld_o[4]), 64'h1);
    check("t4_alu",  alu_o[4],     64'h030201);
    check("t4_code_kept", 64'(ec_o[4]), 64'h1);

    // Display command, and command bytes as frame data.
    do_reset();
    send_byte(8'hD1);
    check("t5_disp", 64'(dp_o[0]), 64'h1);
    send_byte(8'hCD); send_byte(8'hD1);
    check("t5_nodisp", 64'(dp_o[0]), 64'h0);
    send_byte(8'hCD); send_byte(8'h01);
    check("t5_load", 64'(ld_o[0]), 64'h1);
    check("t5_alu",  alu_o[0],     64'h01CDD1);

    // Asynchronous reset mid-frame.
    send_byte(8'hCD); send_byte(8'h05);
    #2 reset_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("t6_alu%0d", g),  alu_o[g],     64'h0);
      check($sformatf("t6_busy%0d", g), 64'(by_o[g]), 64'h0);
      check($sformatf("t6_ld%0d", g),   64'(ld_o[g]), 64'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    send_byte(8'h03); send_byte(8'h20);
    check("t6_idle",   64'(by_o[0]), 64'h0);
    check("t6_noload", 64'(ld_o[0]), 64'h0);
    check("t6_alu",    alu_o[0],     64'h0);

    // Randomized traffic, biased toward headers and valid checksums.
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(99));
      if (r < 15)      b = 8'hCD;
      else if (r < 22) b = 8'hD1;
      else if (r < 45 && m_in[3] != 0 && m_len[3] == 3)
        b = m_fb[3][0] ^ m_fb[3][1] ^ m_fb[3][2];
      else             b = 8'($urandom);
      send_byte(b);
      r = int'($urandom_range(99));
      if (r < 4)       idle(90 + int'($urandom_range(20)));
      else if (r < 30) idle(int'($urandom_range(3)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_controller.md
Name: rx_frame_controller

Overview:
Parametrised receive-side protocol FSM. It sits between uart_rx and the ALU operand register, and is the successor of the fixed 8-bit command decoder. It assembles multi-byte operands of configurable width and optionally checks a frame checksum. An inter-byte timeout aborts stalled frames, and each abort is reported through an error pulse and code.

Parameters:
DATA_W, 8, operand width in bits (1..32); bytes per operand NB = (DATA_W+7)/8
OP_W, 6, opcode width in bits (1..8); taken from the low bits of the opcode byte
CMD_CONFIG, 8'hCD, header byte that starts a config frame
CMD_DISPLAY, 8'hD1, single-byte display command
CHK_EN, 0, 1 = a trailing XOR checksum byte is expected
TIMEOUT_CYCLES, 0, clocks allowed between frame bytes; 0 disables the timeout

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
data_ready_pulse  in  1  one-cycle strobe from uart_rx marking a new byte
data_in  in  8  received byte, valid while data_ready_pulse is high
alu_data_out  out  OP_W+2*DATA_W  {op, B, A}; A in the LSBs
reg_load_pulse  out  1  one-cycle strobe: alu_data_out just updated
display_cmd_pulse  out  1  one-cycle strobe: start result transmission
frame_err_pulse  out  1  one-cycle strobe: frame aborted
frame_err_code  out  2  0 none, 1 timeout, 2 checksum; holds last error
busy  out  1  high in any state other than IDLE and DONE

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; byte counter, timeout counter, checksum and shadow operands cleared.
- States: IDLE, RECV_A, RECV_B, RECV_OP, RECV_CHK, DONE.
- IDLE:
  - Byte == CMD_CONFIG: go to RECV_A; clear the byte counter and checksum.
  - Byte == CMD_DISPLAY: display_cmd_pulse is asserted in the next cycle (registered); stay in IDLE.
  - Any other byte: ignored.
- RECV_A / RECV_B:
  - Collect NB bytes each, little-endian. Byte k goes to shadow bits [8k+7:8k]; bits at or above DATA_W are discarded.
  - After the NB-th byte, advance to RECV_B, then RECV_OP.
- RECV_OP:
  - One byte; shadow op = byte[OP_W-1:0].
  - Next state is RECV_CHK if CHK_EN, otherwise DONE.
- RECV_CHK:
  - Compare the byte with the XOR of all A, B and op bytes (the full 8-bit op byte, header excluded).
  - Match: go to DONE.
  - Mismatch: go to IDLE, pulse frame_err_pulse, set code 2.
- DONE:
  - On the edge entering DONE, alu_data_out <= {op, B, A}.
  - reg_load_pulse is high for the single DONE cycle, i.e. 1 clk after the last frame byte.
  - Next state is IDLE. A byte arriving in the DONE cycle is decoded as if in IDLE.
- Inside a frame, CMD_CONFIG and CMD_DISPLAY bytes are plain data, with no pulse and no restart.
- alu_data_out changes only on a successful frame. Aborted frames leave it untouched.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter runs in RECV_* states and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES with no byte: go to IDLE, pulse frame_err_pulse, set code 1.
  - A byte arriving in the expiry cycle wins and no timeout is raised.
- frame_err_code holds its value until the next error or reset. A successful frame does not clear it.
- Reset asserted mid-frame: the frame is discarded, with no load and no error pulse.
- Illegal state encoding: go to IDLE.

Decomposition:
- Shared package rx_proto_pkg holds:
  - CMD_CONFIG / CMD_DISPLAY defaults
  - state encoding localparams
  - error code constants (ERR_NONE, ERR_TIMEOUT, ERR_CHK)
  - the NB computation function
- One natural sub-module, rx_timeout_counter: parametrised down-counter with clear, enable and expire pulse. It is tied off when TIMEOUT_CYCLES = 0.
- Operand assembly stays inline.

Test Plan:
1. Defaults; bytes CD 05 03 20 -> alu_data_out = 22'h200305. reg_load_pulse is high for exactly one clk, one clk after the 0x20 byte.
2. DATA_W=16; bytes CD 34 12 78 56 22 -> A = 16'h1234, B = 16'h5678, op = 6'h22, one load pulse. With DATA_W=12, the same bytes give A = 12'h234.
3. CHK_EN=1; CD 05 03 20 26 -> load. Then CD 05 03 20 27 -> frame_err_pulse, code 2, no load, alu_data_out still 22'h200305.
4. TIMEOUT_CYCLES=100; CD 05 then idle -> error pulse with code 1 exactly 100 clk after the 05 strobe; busy drops. Then CD 01 02 03 -> normal load.
5. In IDLE, D1 -> display_cmd_pulse one clk later. Then CD D1 CD 01 -> A=D1, B=CD, op=01, no display pulse.
6. Reset_n low after CD 05 -> all outputs 0 asynchronously. After release, bytes 03 20 are ignored (state is IDLE).
